// File: rtl/mc_seq_datapath_regs.sv
// mc_seq_datapath_regs: clocked back-end of the multicycle MIPS core.
// Holds the controller state register, PC, IR, MDR, A, B and ALUOut.
// It also implements PC update, the memory address mux and the memory-ready stall.
// Optional build macro MC_PERF_COUNTERS_EN adds the cycle_cnt and instr_cnt
// performance counters.
module mc_seq_datapath_regs #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ns,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic [1:0]       pc_source,
    input  logic             iord,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             ir_write,
    input  logic             reg_write,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    output logic [3:0]       state,
    output logic [5:0]       op,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] b_reg,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             rf_we,
    output logic             illegal_state
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instr_cnt
`endif
);

    logic [3:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_illegal;

    logic             w_stall;
    logic             w_pc_en;
    logic             w_ns_bad;
    logic             w_retire;

    assign w_stall  = (mem_read | mem_write) & ~mem_ready;
    assign w_pc_en  = ~w_stall & (pc_write | (pc_write_cond & alu_zero));
    assign w_ns_bad = (ns > 4'd9);
    assign w_retire = ~w_stall & (r_state != 4'd0) & (ns == 4'd0);

    // State, PC and inter-cycle datapath registers; everything freezes on a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= 4'd0;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_illegal <= 1'b0;
        end else if (!w_stall) begin
            if (w_ns_bad) begin
                r_state   <= 4'd0;
                r_illegal <= 1'b1;
            end else begin
                r_state <= ns;
            end
            // pc_source 2'b11 is reserved: PC holds even if enabled
            if (w_pc_en) begin
                case (pc_source)
                    2'b00:   r_pc <= alu_result;
                    2'b01:   r_pc <= r_alu_out;
                    2'b10:   r_pc <= {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};
                    default: r_pc <= r_pc;
                endcase
            end
            if (ir_write) begin
                r_ir <= mem_rdata;
            end
            r_mdr     <= mem_rdata;
            r_a       <= rf_rdata1;
            r_b       <= rf_rdata2;
            r_alu_out <= alu_result;
        end
    end

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    // Free-running cycle and retired-instruction counters, wrapping silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
`endif

    assign state         = r_state;
    assign op            = r_ir[31:26];
    assign pc            = r_pc;
    assign ir            = r_ir;
    assign mdr           = r_mdr;
    assign a_reg         = r_a;
    assign b_reg         = r_b;
    assign alu_out       = r_alu_out;
    assign mem_addr      = iord ? r_alu_out : r_pc;
    assign mem_wdata     = r_b;
    assign mem_rd        = mem_read & ~rst;
    assign mem_wr        = mem_write & ~rst;
    assign rf_we         = reg_write & ~w_stall;
    assign illegal_state = r_illegal;

endmodule
